// File: rtl/noc_packet_injector_pkg.sv
// Shared NoC header definitions: default field widths, FSM state type and the header
// packing function used by the injector (and mirrored by the ejector/decoder side).
package noc_packet_injector_pkg;

  localparam int NOC_DATA_W  = 32;
  localparam int NOC_COORD_W = 4;
  localparam int NOC_LEN_W   = 8;
  localparam int HDR_MAX_W   = 64;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } inj_state_t;

  // Header MSB-first: dst_x, dst_y, src_x, src_y, len, then zero padding down to bit 0.
  // Packs into HDR_MAX_W bits; callers truncate to their flit width (data_w <= HDR_MAX_W).
  function automatic logic [HDR_MAX_W-1:0] pack_header(
    input int unsigned           data_w,
    input int unsigned           coord_w,
    input int unsigned           len_w,
    input logic [HDR_MAX_W-1:0]  dst_x,
    input logic [HDR_MAX_W-1:0]  dst_y,
    input logic [HDR_MAX_W-1:0]  src_x,
    input logic [HDR_MAX_W-1:0]  src_y,
    input logic [HDR_MAX_W-1:0]  len
  );
    logic [HDR_MAX_W-1:0] cmask;
    logic [HDR_MAX_W-1:0] lmask;
    logic [HDR_MAX_W-1:0] h;
    cmask = (64'd1 << coord_w) - 64'd1;
    lmask = (64'd1 << len_w) - 64'd1;
    h = dst_x & cmask;
    h = (h << coord_w) | (dst_y & cmask);
    h = (h << coord_w) | (src_x & cmask);
    h = (h << coord_w) | (src_y & cmask);
    h = (h << len_w)   | (len & lmask);
    h = h << (data_w - 4 * coord_w - len_w);
    return h;
  endfunction

endpackage

// File: rtl/noc_packet_injector_if.sv
// Handshake bundle of the packet injector: request, payload stream and router-facing flit port.
interface noc_packet_injector_if #(
  parameter int DATA_W  = 32,
  parameter int COORD_W = 4,
  parameter int LEN_W   = 8
);
  logic               req_valid;
  logic               req_ready;
  logic [COORD_W-1:0] req_dst_x;
  logic [COORD_W-1:0] req_dst_y;
  logic [LEN_W-1:0]   req_len;
  logic               pld_valid;
  logic               pld_ready;
  logic [DATA_W-1:0]  pld_data;
  logic               flit_valid;
  logic               flit_ready;
  logic [DATA_W-1:0]  flit_data;
  logic               flit_is_header;
  logic               flit_is_tail;
  logic               busy;
  logic [15:0]        pkt_sent_cnt;

  // Processing-element / router environment side.
  modport master (
    output req_valid, req_dst_x, req_dst_y, req_len, pld_valid, pld_data, flit_ready,
    input  req_ready, pld_ready, flit_valid, flit_data, flit_is_header, flit_is_tail,
           busy, pkt_sent_cnt
  );

  // Injector side.
  modport slave (
    input  req_valid, req_dst_x, req_dst_y, req_len, pld_valid, pld_data, flit_ready,
    output req_ready, pld_ready, flit_valid, flit_data, flit_is_header, flit_is_tail,
           busy, pkt_sent_cnt
  );
endinterface

// File: rtl/noc_packet_injector.sv
// NoC network-interface transmitter: packet request + payload words -> header/body/tail flits
// through a single registered output stage sustaining one flit per cycle.
module noc_packet_injector
  import noc_packet_injector_pkg::*;
#(
  parameter int DATA_W  = NOC_DATA_W,
  parameter int COORD_W = NOC_COORD_W,
  parameter int LEN_W   = NOC_LEN_W,
  parameter int SRC_X   = 0,
  parameter int SRC_Y   = 0
) (
  input  logic             noc_clk,
  input  logic             rst_n,
  noc_packet_injector_if.slave bus
);

  inj_state_t        state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;

  logic              load_p0;
  logic [DATA_W-1:0] data_p0;
  logic              hdr_p0;
  logic              tail_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] flit_data_p1;
  logic              hdr_p1;
  logic              tail_p1;
  logic [15:0]       pkt_cnt_q;

  logic              slot_free;
  logic [DATA_W-1:0] hdr_word;

  assign slot_free = !vld_p1 || bus.flit_ready;

  assign hdr_word = DATA_W'(pack_header(DATA_W, COORD_W, LEN_W,
                                        64'(bus.req_dst_x), 64'(bus.req_dst_y),
                                        64'(SRC_X), 64'(SRC_Y), 64'(bus.req_len)));

  always_ff @(posedge noc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    load_p0       = 1'b0;
    data_p0       = flit_data_p1;
    hdr_p0        = 1'b0;
    tail_p0       = 1'b0;
    bus.req_ready = 1'b0;
    bus.pld_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = slot_free && rst_n;
        if (bus.req_valid && slot_free && rst_n) begin
          load_p0     = 1'b1;
          data_p0     = hdr_word;
          hdr_p0      = 1'b1;
          tail_p0     = (bus.req_len == '0);
          remaining_d = bus.req_len;
          state_d     = (bus.req_len == '0) ? IDLE : BODY;
        end
      end
      BODY: begin
        bus.pld_ready = slot_free && rst_n;
        if (bus.pld_valid && slot_free && rst_n) begin
          load_p0     = 1'b1;
          data_p0     = bus.pld_data;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            tail_p0 = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- p0 -> p1: output register, holds while a presented flit is not yet accepted ----
  always_ff @(posedge noc_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      flit_data_p1 <= '0;
      hdr_p1       <= 1'b0;
      tail_p1      <= 1'b0;
      pkt_cnt_q    <= '0;
    end else begin
      if (slot_free) begin
        vld_p1  <= load_p0;
        hdr_p1  <= hdr_p0;
        tail_p1 <= tail_p0;
        if (load_p0) flit_data_p1 <= data_p0;
      end
      if (vld_p1 && bus.flit_ready && tail_p1) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign bus.flit_valid     = vld_p1;
  assign bus.flit_data      = flit_data_p1;
  assign bus.flit_is_header = hdr_p1;
  assign bus.flit_is_tail   = tail_p1;
  assign bus.pkt_sent_cnt   = pkt_cnt_q;
  assign bus.busy           = (state_q != IDLE) || vld_p1;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed bench for noc_packet_injector: expected-flit queue filled by the stimulus tasks,
// a per-cycle compare process, and literal spot checks of header layout and counters.
module tb_noc_packet_injector;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  noc_packet_injector_if #(.DATA_W(DW), .COORD_W(4), .LEN_W(8)) bus ();

  noc_packet_injector #(
    .DATA_W(DW), .COORD_W(4), .LEN_W(8), .SRC_X(1), .SRC_Y(2)
  ) dut (
    .noc_clk(clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          hdr;
    logic          tail;
  } flit_t;

  flit_t       exp_q[$];
  int          hs_cyc[$];
  bit          hs_hdr[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] model_cnt = 16'd0;
  bit          prev_stall = 1'b0;
  flit_t       prev;

  // Header of this node (SRC=(1,2)) as plain field concatenation.
  function automatic logic [DW-1:0] exp_hdr(input logic [3:0] dx, input logic [3:0] dy,
                                            input logic [7:0] len);
    return {dx, dy, 4'd1, 4'd2, len, 8'h00};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare: counter, hold-while-stalled, and every accepted flit against the queue.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (rst_n) begin
      n_checks++;
      if (bus.pkt_sent_cnt !== model_cnt) begin
        n_fail++;
        $display("FAIL pkt_sent_cnt cyc %0d: got %0d expected %0d", cyc, bus.pkt_sent_cnt, model_cnt);
      end
      if (prev_stall) begin
        n_checks++;
        if (!(bus.flit_valid === 1'b1 && bus.flit_data === prev.data &&
              bus.flit_is_header === prev.hdr && bus.flit_is_tail === prev.tail)) begin
          n_fail++;
          $display("FAIL stall_hold cyc %0d: got v=%0b d=%0h h=%0b t=%0b expected v=1 d=%0h h=%0b t=%0b",
                   cyc, bus.flit_valid, bus.flit_data, bus.flit_is_header, bus.flit_is_tail,
                   prev.data, prev.hdr, prev.tail);
        end
      end
      if (bus.flit_valid && bus.flit_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_flit cyc %0d: got d=%0h expected none", cyc, bus.flit_data);
        end else begin
          flit_t e;
          e = exp_q.pop_front();
          if (bus.flit_data !== e.data || bus.flit_is_header !== e.hdr || bus.flit_is_tail !== e.tail) begin
            n_fail++;
            $display("FAIL flit cyc %0d: got d=%0h h=%0b t=%0b expected d=%0h h=%0b t=%0b",
                     cyc, bus.flit_data, bus.flit_is_header, bus.flit_is_tail, e.data, e.hdr, e.tail);
          end
          if (e.tail) model_cnt = model_cnt + 16'd1;
        end
        hs_cyc.push_back(cyc);
        hs_hdr.push_back(bus.flit_is_header);
      end
      prev_stall = bus.flit_valid && !bus.flit_ready;
      prev.data  = bus.flit_data;
      prev.hdr   = bus.flit_is_header;
      prev.tail  = bus.flit_is_tail;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send_req(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] len);
    bit done = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_dst_x = dx;
    bus.req_dst_y = dy;
    bus.req_len   = len;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (bus.req_ready) begin
        exp_q.push_back('{exp_hdr(dx, dy, len), 1'b1, (len == 8'd0)});
        done = 1'b1;
        @(posedge clk);
        #1;
      end else begin
        @(negedge clk);
      end
    end
    bus.req_valid = 1'b0;
    if (!done) chk("req_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_pld(input logic [DW-1:0] word, input bit tail);
    bit done = 1'b0;
    @(negedge clk);
    bus.pld_valid = 1'b1;
    bus.pld_data  = word;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (bus.pld_ready) begin
        exp_q.push_back('{word, 1'b0, tail});
        done = 1'b1;
        @(posedge clk);
        #1;
      end else begin
        @(negedge clk);
      end
    end
    bus.pld_valid = 1'b0;
    if (!done) chk("pld_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic burst(input int n);
    int got = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_dst_x = 4'd5;
    bus.req_dst_y = 4'd5;
    bus.req_len   = 8'd0;
    for (int i = 0; i < n + 100 && got < n; i++) begin
      #1;
      if (bus.req_ready) begin
        exp_q.push_back('{exp_hdr(4'd5, 4'd5, 8'd0), 1'b1, 1'b1});
        got++;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    if (got != n) chk("burst_timeout", 64'(got), 64'(n));
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0 && !bus.flit_valid) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    int nh;
    bus.req_valid = 1'b0;
    bus.req_dst_x = '0;
    bus.req_dst_y = '0;
    bus.req_len   = '0;
    bus.pld_valid = 1'b0;
    bus.pld_data  = '0;
    bus.flit_ready = 1'b1;

    // Reset state
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_pld_ready", 64'(bus.pld_ready), 64'd0);
    chk("rst_flit_valid", 64'(bus.flit_valid), 64'd0);
    chk("rst_flit_data", 64'(bus.flit_data), 64'd0);
    chk("rst_cnt", 64'(bus.pkt_sent_cnt), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // len=0 to (2,3): single header+tail flit, one cycle after acceptance
    send_req(4'd2, 4'd3, 8'd0);
    chk("t1_valid", 64'(bus.flit_valid), 64'd1);
    chk("t1_data", 64'(bus.flit_data), 64'h2312_0000);
    chk("t1_hdr", 64'(bus.flit_is_header), 64'd1);
    chk("t1_tail", 64'(bus.flit_is_tail), 64'd1);
    @(posedge clk);
    #1;
    chk("t1_cnt", 64'(bus.pkt_sent_cnt), 64'd1);
    wait_drain();

    // len=3 A,B,C: four consecutive flits
    h0 = hs_cyc.size();
    send_req(4'd4, 4'd5, 8'd3);
    send_pld(32'hAAAA_0001, 1'b0);
    send_pld(32'hBBBB_0002, 1'b0);
    send_pld(32'hCCCC_0003, 1'b1);
    wait_drain();
    chk("t2_flits", 64'(hs_cyc.size() - h0), 64'd4);
    if (hs_cyc.size() - h0 == 4) chk("t2_span", 64'(hs_cyc[h0+3] - hs_cyc[h0]), 64'd3);
    chk("t2_busy", 64'(bus.busy), 64'd0);
    chk("t2_cnt", 64'(bus.pkt_sent_cnt), 64'd2);

    // Router stalls 5 cycles mid-packet
    send_req(4'd1, 4'd1, 8'd4);
    send_pld(32'h1111_0000, 1'b0);
    @(negedge clk);
    bus.flit_ready = 1'b0;
    bus.pld_valid  = 1'b1;
    bus.pld_data   = 32'h2222_0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_pld_ready", 64'(bus.pld_ready), 64'd0);
      chk("t3_valid", 64'(bus.flit_valid), 64'd1);
      chk("t3_data", 64'(bus.flit_data), 64'h1111_0000);
      @(negedge clk);
    end
    bus.pld_valid  = 1'b0;
    bus.flit_ready = 1'b1;
    send_pld(32'h2222_0000, 1'b0);
    send_pld(32'h3333_0000, 1'b0);
    send_pld(32'h4444_0000, 1'b1);
    wait_drain();
    chk("t3_cnt", 64'(bus.pkt_sent_cnt), 64'd3);

    // Two len=2 packets back-to-back: six flits in six cycles
    h0 = hs_cyc.size();
    send_req(4'd6, 4'd7, 8'd2);
    send_pld(32'h0000_00A1, 1'b0);
    send_pld(32'h0000_00A2, 1'b1);
    send_req(4'd8, 4'd9, 8'd2);
    send_pld(32'h0000_00B1, 1'b0);
    send_pld(32'h0000_00B2, 1'b1);
    wait_drain();
    chk("t4_flits", 64'(hs_cyc.size() - h0), 64'd6);
    if (hs_cyc.size() - h0 == 6) begin
      chk("t4_span", 64'(hs_cyc[h0+5] - hs_cyc[h0]), 64'd5);
      nh = 0;
      for (int i = h0; i < h0 + 6; i++) nh += int'(hs_hdr[i]);
      chk("t4_headers", 64'(nh), 64'd2);
    end
    chk("t4_cnt", 64'(bus.pkt_sent_cnt), 64'd5);

    // Asynchronous reset in BODY after 1 of 4 payload words
    send_req(4'd3, 4'd3, 8'd4);
    send_pld(32'h5555_0000, 1'b0);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", 64'(bus.flit_valid), 64'd0);
    chk("t5_data", 64'(bus.flit_data), 64'd0);
    chk("t5_flags", 64'({bus.flit_is_header, bus.flit_is_tail}), 64'd0);
    chk("t5_busy", 64'(bus.busy), 64'd0);
    chk("t5_ready", 64'({bus.req_ready, bus.pld_ready}), 64'd0);
    chk("t5_cnt", 64'(bus.pkt_sent_cnt), 64'd0);
    exp_q.delete();
    model_cnt = 16'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_req(4'd10, 4'd11, 8'd1);
    send_pld(32'h6666_0000, 1'b1);
    wait_drain();
    chk("t5_new_cnt", 64'(bus.pkt_sent_cnt), 64'd1);

    // Counter wrap: 1 + 65534 -> 0xFFFF, one more -> 0
    burst(65534);
    wait_drain();
    chk("t6_cnt_max", 64'(bus.pkt_sent_cnt), 64'hFFFF);
    burst(1);
    wait_drain();
    chk("t6_cnt_wrap", 64'(bus.pkt_sent_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
